operand_fetch: RTL and testbench

OPERAND_FETCH -- requirements
Module: operand_fetch

---
 rtl/operand_fetch_if.sv | 22 ++
 rtl/operand_fetch.sv | 206 ++++++++++++++++++++
 tb/tb_operand_fetch.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/operand_fetch_if.sv
// Upstream/downstream handshake bundle for the operand fetch stage.
// The slave modport is the fetch stage's view; master is the surrounding pipeline.
interface operand_fetch_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_rs_val;
  logic [31:0] out_rt_val;

  modport master (
    output in_valid, in_instr, out_ready,
    input  in_ready, out_valid, out_instr, out_rs_val, out_rt_val
  );

  modport slave (
    input  in_valid, in_instr, out_ready,
    output in_ready, out_valid, out_instr, out_rs_val, out_rt_val
  );
endinterface

// File: rtl/operand_fetch.sv
// Operand fetch stage: accepts an instruction, reads rs/rt from a register
// file with one-cycle registered read, and resolves writeback hazards so the
// operands presented downstream always carry the newest written value.
module operand_fetch (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  operand_fetch_if.slave  bus,
  output logic [31:0]     rf_Aa,
  output logic [31:0]     rf_Ab,
  input  logic [31:0]     rf_Da,
  input  logic [31:0]     rf_Db,
  input  logic            wb_wren,
  input  logic [4:0]      wb_aw,
  input  logic [31:0]     wb_dw
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2
  } state_e;

  state_e      state_q,     state_d;
  logic        in_ready_q,  in_ready_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] instr_q,     instr_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic [31:0] rs_val_q,    rs_val_d;
  logic [31:0] rt_val_q,    rt_val_d;
  // Write that landed on the accept edge; the register file read for that
  // edge returns the pre-write value, so it must be bypassed in FETCH.
  logic        pend_v_q,    pend_v_d;
  logic [4:0]  pend_a_q,    pend_a_d;
  logic [31:0] pend_dat_q,  pend_dat_d;

  logic [31:0] addr_instr;
  logic [4:0]  held_rs;
  logic [4:0]  held_rt;

  // Operand resolution: r0 is hard zero, then live writeback, then the
  // pending accept-edge write, then the register file data.
  function automatic logic [31:0] resolve_operand(
    input logic [4:0]  idx,
    input logic [31:0] rf_data,
    input logic        live_en,
    input logic [4:0]  live_a,
    input logic [31:0] live_d,
    input logic        pnd_en,
    input logic [4:0]  pnd_a,
    input logic [31:0] pnd_d
  );
    logic [31:0] r;
    if (idx == 5'd0) begin
      r = 32'd0;
    end else if (live_en && (live_a == idx)) begin
      r = live_d;
    end else if (pnd_en && (pnd_a == idx)) begin
      r = pnd_d;
    end else begin
      r = rf_data;
    end
    return r;
  endfunction

  assign held_rs = instr_q[25:21];
  assign held_rt = instr_q[20:16];

  // Register-file addresses: follow the incoming word while idle so the
  // file samples them on the accept edge, otherwise the latched word.
  always_comb begin
    addr_instr = instr_q;
    if (state_q == IDLE) begin
      addr_instr = bus.in_instr;
    end else begin
      addr_instr = instr_q;
    end
    rf_Aa = {27'd0, addr_instr[25:21]};
    rf_Ab = {27'd0, addr_instr[20:16]};
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_instr  = out_instr_q;
  assign bus.out_rs_val = rs_val_q;
  assign bus.out_rt_val = rt_val_q;

  // Next-state and datapath for the IDLE -> FETCH -> VALID handshake.
  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    instr_d     = instr_q;
    out_instr_d = out_instr_q;
    rs_val_d    = rs_val_q;
    rt_val_d    = rt_val_q;
    pend_v_d    = pend_v_q;
    pend_a_d    = pend_a_q;
    pend_dat_d  = pend_dat_q;

    case (state_q)
      IDLE: begin
        if (flush) begin
          // Flush cancels an accept even though in_ready is high.
          pend_v_d    = 1'b0;
          in_ready_d  = 1'b1;
          out_valid_d = 1'b0;
        end else if (bus.in_valid) begin
          instr_d    = bus.in_instr;
          pend_v_d   = wb_wren;
          pend_a_d   = wb_aw;
          pend_dat_d = wb_dw;
          state_d    = FETCH;
          in_ready_d = 1'b0;
        end else begin
          in_ready_d  = 1'b1;
          out_valid_d = 1'b0;
        end
      end

      FETCH: begin
        if (flush) begin
          state_d     = IDLE;
          in_ready_d  = 1'b1;
          out_valid_d = 1'b0;
          pend_v_d    = 1'b0;
        end else begin
          rs_val_d    = resolve_operand(held_rs, rf_Da, wb_wren, wb_aw, wb_dw,
                                        pend_v_q, pend_a_q, pend_dat_q);
          rt_val_d    = resolve_operand(held_rt, rf_Db, wb_wren, wb_aw, wb_dw,
                                        pend_v_q, pend_a_q, pend_dat_q);
          out_instr_d = instr_q;
          pend_v_d    = 1'b0;
          state_d     = VALID;
          out_valid_d = 1'b1;
          in_ready_d  = 1'b0;
        end
      end

      VALID: begin
        if (flush) begin
          state_d     = IDLE;
          in_ready_d  = 1'b1;
          out_valid_d = 1'b0;
          pend_v_d    = 1'b0;
        end else begin
          // Keep held operands coherent with writebacks while waiting.
          if (wb_wren && (wb_aw != 5'd0) && (wb_aw == held_rs)) begin
            rs_val_d = wb_dw;
          end else begin
            rs_val_d = rs_val_q;
          end
          if (wb_wren && (wb_aw != 5'd0) && (wb_aw == held_rt)) begin
            rt_val_d = wb_dw;
          end else begin
            rt_val_d = rt_val_q;
          end
          if (bus.out_ready) begin
            state_d     = IDLE;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
          end else begin
            state_d     = VALID;
            in_ready_d  = 1'b0;
            out_valid_d = 1'b1;
          end
        end
      end

      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        pend_v_d    = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      instr_q     <= 32'd0;
      out_instr_q <= 32'd0;
      rs_val_q    <= 32'd0;
      rt_val_q    <= 32'd0;
      pend_v_q    <= 1'b0;
      pend_a_q    <= 5'd0;
      pend_dat_q  <= 32'd0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      instr_q     <= instr_d;
      out_instr_q <= out_instr_d;
      rs_val_q    <= rs_val_d;
      rt_val_q    <= rt_val_d;
      pend_v_q    <= pend_v_d;
      pend_a_q    <= pend_a_d;
      pend_dat_q  <= pend_dat_d;
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: a register-file model with one-cycle registered
// read, directed stimulus pushing expected transfers into a scoreboard, and
// a monitor that pops and compares on every downstream handshake.
module tb_operand_fetch;

  logic        clk;
  logic        reset;
  logic        flush;
  logic [31:0] rf_Aa, rf_Ab, rf_Da, rf_Db;
  logic        wb_wren;
  logic [4:0]  wb_aw;
  logic [31:0] wb_dw;
  logic        rf_clr;

  operand_fetch_if bus ();

  operand_fetch dut (
    .clk     (clk),
    .reset   (reset),
    .flush   (flush),
    .bus     (bus.slave),
    .rf_Aa   (rf_Aa),
    .rf_Ab   (rf_Ab),
    .rf_Da   (rf_Da),
    .rf_Db   (rf_Db),
    .wb_wren (wb_wren),
    .wb_aw   (wb_aw),
    .wb_dw   (wb_dw)
  );

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] rs;
    logic [31:0] rt;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] regs [32];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register-file model: read returns the value before a same-edge write.
  always @(posedge clk) begin
    if (rf_clr) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
      rf_Da <= 32'd0;
      rf_Db <= 32'd0;
    end else begin
      rf_Da <= regs[rf_Aa[4:0]];
      rf_Db <= regs[rf_Ab[4:0]];
      if (wb_wren) regs[wb_aw] <= wb_dw;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: every downstream transfer must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_xfer actual=%h required=none", bus.out_instr);
      end else begin
        e = sb.pop_front();
        chk("xfer_instr", bus.out_instr,  e.instr);
        chk("xfer_rs",    bus.out_rs_val, e.rs);
        chk("xfer_rt",    bus.out_rt_val, e.rt);
      end
    end
  end

  function automatic logic [31:0] mk(input logic [4:0] rs, input logic [4:0] rt,
                                     input logic [15:0] lo);
    return {6'h23, rs, rt, lo};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic en, input logic [4:0] a, input logic [31:0] d);
    wb_wren = en;
    wb_aw   = a;
    wb_dw   = d;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    wb(1'b1, a, d);
    tick();
    wb(1'b0, 5'd0, 32'd0);
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] i5;
    reset = 1'b1; flush = 1'b0; rf_clr = 1'b1;
    bus.in_valid = 1'b0; bus.in_instr = 32'd0; bus.out_ready = 1'b1;
    wb(1'b0, 5'd0, 32'd0);
    tick(); tick();
    rf_clr = 1'b0;
    // Preload while the block is still held in reset.
    wr(5'd3, 32'h11);
    wr(5'd4, 32'h22);
    reset = 1'b0;

    // Reset state, then accept in the very first cycle after reset.
    chk("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_out_instr", bus.out_instr,  32'd0);
    chk("rst_rs",        bus.out_rs_val, 32'd0);
    chk("rst_rt",        bus.out_rt_val, 32'd0);

    // Basic fetch with latency 2.
    sb.push_back('{mk(5'd3, 5'd4, 16'h0001), 32'h11, 32'h22});
    bus.in_valid = 1'b1; bus.in_instr = mk(5'd3, 5'd4, 16'h0001);
    #1;
    chk("addr_a", rf_Aa, 32'd3);
    chk("addr_b", rf_Ab, 32'd4);
    tick();
    bus.in_valid = 1'b0;
    chk("fetch_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("fetch_in_ready",  {31'd0, bus.in_ready},  32'd0);
    tick();
    chk("lat2_out_valid", {31'd0, bus.out_valid}, 32'd1);
    tick();

    // Accept-edge write r3=AB; register file returns stale 0x11.
    sb.push_back('{mk(5'd3, 5'd4, 16'h0002), 32'hAB, 32'h22});
    bus.in_valid = 1'b1; bus.in_instr = mk(5'd3, 5'd4, 16'h0002);
    wb(1'b1, 5'd3, 32'hAB);
    tick();
    bus.in_valid = 1'b0; wb(1'b0, 5'd0, 32'd0);
    tick(); tick();

    // Live write r4=CD during FETCH.
    sb.push_back('{mk(5'd3, 5'd4, 16'h0003), 32'hAB, 32'hCD});
    bus.in_valid = 1'b1; bus.in_instr = mk(5'd3, 5'd4, 16'h0003);
    tick();
    bus.in_valid = 1'b0; wb(1'b1, 5'd4, 32'hCD);
    tick();
    wb(1'b0, 5'd0, 32'd0);
    tick();

    // rs=0 with writes to r0 on both the accept and FETCH edges.
    sb.push_back('{mk(5'd0, 5'd4, 16'h0004), 32'h0, 32'hCD});
    bus.in_valid = 1'b1; bus.in_instr = mk(5'd0, 5'd4, 16'h0004);
    wb(1'b1, 5'd0, 32'hFF);
    tick();
    bus.in_valid = 1'b0;
    tick();
    wb(1'b0, 5'd0, 32'd0);
    tick();

    // Backpressure for 5 cycles with a write r3=55 in the second one.
    i5 = mk(5'd3, 5'd4, 16'h0005);
    sb.push_back('{i5, 32'h55, 32'hCD});
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_instr = i5;
    tick();
    bus.in_valid = 1'b0;
    tick();
    for (int c = 0; c < 5; c++) begin
      chk("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("bp_in_ready",  {31'd0, bus.in_ready},  32'd0);
      chk("bp_instr",     bus.out_instr,  i5);
      chk("bp_rt",        bus.out_rt_val, 32'hCD);
      chk("bp_rs",        bus.out_rs_val, (c < 2) ? 32'hAB : 32'h55);
      if (c == 1) wb(1'b1, 5'd3, 32'h55);
      else        wb(1'b0, 5'd0, 32'd0);
      tick();
    end
    wb(1'b0, 5'd0, 32'd0);
    bus.out_ready = 1'b1;
    tick();

    // rs == rt == 7 with a pending accept-edge write r7=99.
    wr(5'd7, 32'h01);
    sb.push_back('{mk(5'd7, 5'd7, 16'h0006), 32'h99, 32'h99});
    bus.in_valid = 1'b1; bus.in_instr = mk(5'd7, 5'd7, 16'h0006);
    wb(1'b1, 5'd7, 32'h99);
    tick();
    bus.in_valid = 1'b0; wb(1'b0, 5'd0, 32'd0);
    tick(); tick();

    // Flush in IDLE coincident with in_valid cancels the accept.
    bus.in_valid = 1'b1; bus.in_instr = mk(5'd3, 5'd4, 16'h0007); flush = 1'b1;
    chk("fidle_in_ready", {31'd0, bus.in_ready}, 32'd1);
    tick();
    bus.in_valid = 1'b0; flush = 1'b0;
    chk("fidle_still_idle", {31'd0, bus.in_ready}, 32'd1);
    tick();
    chk("fidle_no_valid", {31'd0, bus.out_valid}, 32'd0);

    // Flush in FETCH.
    bus.in_valid = 1'b1; bus.in_instr = mk(5'd3, 5'd4, 16'h0008);
    tick();
    bus.in_valid = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("ffetch_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("ffetch_in_ready",  {31'd0, bus.in_ready},  32'd1);
    tick();
    chk("ffetch_stays_idle", {31'd0, bus.out_valid}, 32'd0);

    // Reset in VALID drops the instruction.
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_instr = mk(5'd3, 5'd4, 16'h0009);
    tick();
    bus.in_valid = 1'b0;
    tick();
    chk("rv_out_valid_pre", {31'd0, bus.out_valid}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.out_ready = 1'b1;
    chk("rv_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rv_in_ready",  {31'd0, bus.in_ready},  32'd1);
    chk("rv_out_instr", bus.out_instr,  32'd0);
    chk("rv_rs",        bus.out_rs_val, 32'd0);
    chk("rv_rt",        bus.out_rt_val, 32'd0);

    // Subsequent accept behaves like the basic case.
    wr(5'd3, 32'h11);
    wr(5'd4, 32'h22);
    sb.push_back('{mk(5'd3, 5'd4, 16'h000A), 32'h11, 32'h22});
    bus.in_valid = 1'b1; bus.in_instr = mk(5'd3, 5'd4, 16'h000A);
    tick();
    bus.in_valid = 1'b0;
    tick();
    chk("post_lat2_valid", {31'd0, bus.out_valid}, 32'd1);
    tick(); tick(); tick();

    chk("sb_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
